// File: rtl/sort_result_serializer_if.sv
// Bundle between the bitonic sorter output and a narrow element-stream consumer.
// Handshake: m_data/m_index/m_last are meaningful only while m_valid=1; a beat moves on a
// rising edge with m_valid && m_ready, and m_valid never drops before its beat moves.
interface sort_result_serializer_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                 valid_in;
    logic [0:WIDTH-1]     seq_in [0:DEPTH-1];
    logic [WIDTH-1:0]     m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;
    logic [IW-1:0]        m_index;
    logic [1:0]           slots_free;
    logic                 overflow;
    logic [7:0]           drop_count;
    logic                 dbg_stream;

    modport master (
        input  valid_in, seq_in, m_ready,
        output m_data, m_valid, m_last, m_index, slots_free, overflow, drop_count, dbg_stream
    );

    modport slave (
        output valid_in, seq_in, m_ready,
        input  m_data, m_valid, m_last, m_index, slots_free, overflow, drop_count, dbg_stream
    );
endinterface

// File: rtl/sort_result_serializer.sv
// Captures whole sorted vectors into a two-slot ping-pong buffer and streams them out one
// element per cycle; vectors arriving with no slot available are dropped and counted.
module sort_result_serializer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    sort_result_serializer_if.master  bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_slot [0:1][0:DEPTH-1];
    logic [1:0]        r_full;
    logic [1:0]        w_full_nxt;
    logic              r_wr_sel;
    logic              r_rd_sel;
    logic [IW-1:0]     r_index;
    logic [1:0]        r_slots_free;
    logic              r_overflow;
    logic [7:0]        r_drop_count;
    logic              w_xfer;
    logic              w_last_idx;
    logic              w_release;
    logic              w_capture;
    logic              w_drop;

    assign w_last_idx = (r_index == LAST_IDX);
    assign w_xfer     = (r_state == S_STREAM) && bus.m_ready;
    assign w_release  = w_xfer && w_last_idx;
    // With both slots full the write pointer has caught up to the read pointer, so a slot
    // freed by the final beat on this edge is exactly the one the new vector lands in.
    assign w_capture  = bus.valid_in &&
                        (!r_full[r_wr_sel] || (w_release && (r_rd_sel == r_wr_sel)));
    assign w_drop     = bus.valid_in && !w_capture;

    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[r_rd_sel] = 1'b0;
        if (w_capture) w_full_nxt[r_wr_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_full[r_rd_sel]) w_state_nxt = S_STREAM;
            S_STREAM: if (w_release && !w_full_nxt[~r_rd_sel]) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.m_valid    = 1'b0;
        bus.m_data     = '0;
        bus.m_last     = 1'b0;
        bus.dbg_stream = 1'b0;
        if (r_state == S_STREAM) begin
            bus.m_valid    = 1'b1;
            bus.m_data     = r_slot[r_rd_sel][r_index];
            bus.m_last     = w_last_idx;
            bus.dbg_stream = 1'b1;
        end
    end

    // Slot storage is pure datapath; occupancy flags guard its contents after reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[r_wr_sel][i] <= bus.seq_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full       <= 2'b00;
            r_wr_sel     <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_index      <= '0;
            r_slots_free <= 2'd2;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_full       <= w_full_nxt;
            r_slots_free <= 2'd2 - {1'b0, w_full_nxt[0]} - {1'b0, w_full_nxt[1]};
            if (w_capture) r_wr_sel <= ~r_wr_sel;
            if (w_release) begin
                r_rd_sel <= ~r_rd_sel;
                r_index  <= '0;
            end else if (w_xfer) begin
                r_index  <= r_index + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign bus.m_index    = r_index;
    assign bus.slots_free = r_slots_free;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
endmodule
